// File: rtl/issue_if.sv
// rtl/issue_if.sv - issue stage bundle: queue pop, register-file read, unit dispatch, writeback, flush
//
// Ports (master = issue unit side):
//   issue_q_rok/ren/rdata      pop handshake with the decoded-instruction queue
//   rf_rs1/rs2_addr/data       combinational register-file read
//   <unit>_valid/<unit>_ready  per-unit dispatch handshake (alu, lsu, bpu, csr)
//   disp_*                     dispatched payload shared by all units
//   wb_valid/wb_rd             writeback event clearing a scoreboard bit
//   flush                      squash of the held entry
interface issue_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int ISSUE_Q_WIDTH = 123
);
   logic                     issue_q_rok;
   logic                     issue_q_ren;
   logic [ISSUE_Q_WIDTH-1:0] issue_q_rdata;

   logic [4:0]               rf_rs1_addr;
   logic [4:0]               rf_rs2_addr;
   logic [DATA_WIDTH-1:0]    rf_rs1_data;
   logic [DATA_WIDTH-1:0]    rf_rs2_data;

   logic                     alu_valid;
   logic                     lsu_valid;
   logic                     bpu_valid;
   logic                     csr_valid;
   logic                     alu_ready;
   logic                     lsu_ready;
   logic                     bpu_ready;
   logic                     csr_ready;

   logic [3:0]               disp_op;
   logic [3:0]               disp_opsel;
   logic [DATA_WIDTH-1:0]    disp_opa;
   logic [DATA_WIDTH-1:0]    disp_opb;
   logic [DATA_WIDTH-1:0]    disp_rs1_data;
   logic [DATA_WIDTH-1:0]    disp_rs2_data;
   logic [DATA_WIDTH-1:0]    disp_imm;
   logic [4:0]               disp_rs1_idx;
   logic [4:0]               disp_rd;
   logic                     disp_rd_wen;
   logic                     disp_taken;
   logic [ADDR_WIDTH-1:0]    disp_cur_pc;
   logic [ADDR_WIDTH-1:0]    disp_nxt_pc;

   logic                     wb_valid;
   logic [4:0]               wb_rd;
   logic                     flush;

   modport master (
      input  issue_q_rok, issue_q_rdata,
      output issue_q_ren,
      output rf_rs1_addr, rf_rs2_addr,
      input  rf_rs1_data, rf_rs2_data,
      output alu_valid, lsu_valid, bpu_valid, csr_valid,
      input  alu_ready, lsu_ready, bpu_ready, csr_ready,
      output disp_op, disp_opsel, disp_opa, disp_opb,
      output disp_rs1_data, disp_rs2_data, disp_imm, disp_rs1_idx,
      output disp_rd, disp_rd_wen, disp_taken, disp_cur_pc, disp_nxt_pc,
      input  wb_valid, wb_rd, flush
   );

   modport slave (
      output issue_q_rok, issue_q_rdata,
      input  issue_q_ren,
      input  rf_rs1_addr, rf_rs2_addr,
      output rf_rs1_data, rf_rs2_data,
      input  alu_valid, lsu_valid, bpu_valid, csr_valid,
      output alu_ready, lsu_ready, bpu_ready, csr_ready,
      input  disp_op, disp_opsel, disp_opa, disp_opb,
      input  disp_rs1_data, disp_rs2_data, disp_imm, disp_rs1_idx,
      input  disp_rd, disp_rd_wen, disp_taken, disp_cur_pc, disp_nxt_pc,
      output wb_valid, wb_rd, flush
   );
endinterface

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - in-order single-entry issue stage with register scoreboard
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   bus         issue_if.master: queue pop, rf read, dispatch to alu/lsu/bpu/csr,
//               writeback and flush
//   stall_cnt   saturating count of cycles the held entry could not fire
module issue_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int ISSUE_Q_WIDTH = 123,
   parameter int REG_NUM       = 32
) (
   input  logic        clk,
   input  logic        rst,
   issue_if.master     bus,
   output logic [31:0] stall_cnt
);

   typedef enum logic {S_EMPTY = 1'b0, S_HELD = 1'b1} state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [ISSUE_Q_WIDTH-1:0] entry_q;
   logic [REG_NUM-1:0]       busy_q;
   logic [REG_NUM-1:0]       busy_d;
   logic [31:0]              stall_cnt_q;

   // Held-entry fields
   logic [1:0]            func;
   logic [3:0]            op;
   logic [3:0]            opsel;
   logic                  use_rs1;
   logic                  use_rs2;
   logic                  use_imm;
   logic                  use_pc;
   logic [DATA_WIDTH-1:0] imm;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [4:0]            rd;
   logic                  rd_wen;
   logic                  taken;
   logic [ADDR_WIDTH-1:0] nxt_pc;
   logic [ADDR_WIDTH-1:0] cur_pc;

   assign func    = entry_q[122:121];
   assign op      = entry_q[120:117];
   assign opsel   = entry_q[116:113];
   assign use_rs1 = opsel[3];
   assign use_rs2 = opsel[2];
   assign use_imm = opsel[1];
   assign use_pc  = opsel[0];
   assign imm     = entry_q[112:81];
   assign rs1     = entry_q[80:76];
   assign rs2     = entry_q[75:71];
   assign rd      = entry_q[70:66];
   assign rd_wen  = entry_q[65];
   assign taken   = entry_q[64];
   assign nxt_pc  = entry_q[63:32];
   assign cur_pc  = entry_q[31:0];

   logic held;
   logic hazard;
   logic sel_ready;
   logic disp_valid;
   logic fire;
   logic load;

   assign held = (state_q == S_HELD);

   // Registered scoreboard only: a writeback in this cycle is not visible
   // until the next one, so rf data is always read after the write landed.
   assign hazard = held &
                   ((use_rs1 & (rs1 != 5'd0) & busy_q[rs1]) |
                    (use_rs2 & (rs2 != 5'd0) & busy_q[rs2]) |
                    (rd_wen  & (rd  != 5'd0) & busy_q[rd]));

   always_comb begin
      sel_ready = 1'b0;
      case (func)
         2'd0:    sel_ready = bus.alu_ready;
         2'd1:    sel_ready = bus.lsu_ready;
         2'd2:    sel_ready = bus.bpu_ready;
         default: sel_ready = bus.csr_ready;
      endcase
   end

   assign disp_valid = held & ~hazard & ~bus.flush;
   assign fire       = disp_valid & sel_ready;
   assign load       = bus.issue_q_ren & bus.issue_q_rok;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = S_EMPTY;
      end else if (load) begin
         state_d = S_HELD;
      end else if (fire) begin
         state_d = S_EMPTY;
      end
   end

   // Output logic: pop request and one-hot dispatch valid
   always_comb begin
      bus.issue_q_ren = ~bus.flush & (~held | fire);
      bus.alu_valid   = 1'b0;
      bus.lsu_valid   = 1'b0;
      bus.bpu_valid   = 1'b0;
      bus.csr_valid   = 1'b0;
      if (disp_valid) begin
         case (func)
            2'd0:    bus.alu_valid = 1'b1;
            2'd1:    bus.lsu_valid = 1'b1;
            2'd2:    bus.bpu_valid = 1'b1;
            default: bus.csr_valid = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
      end else if (load) begin
         entry_q <= bus.issue_q_rdata;
      end
   end

   // Clear first, then set, so a same-cycle dispatch to the register being
   // written back leaves it busy for the newer producer.
   always_comb begin
      busy_d = busy_q;
      if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
         busy_d[bus.wb_rd] = 1'b0;
      end
      if (fire && rd_wen && (rd != 5'd0)) begin
         busy_d[rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (held && (hazard || !sel_ready) && !bus.flush &&
                   (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;

   assign bus.rf_rs1_addr = held ? rs1 : 5'd0;
   assign bus.rf_rs2_addr = held ? rs2 : 5'd0;

   assign bus.disp_op       = op;
   assign bus.disp_opsel    = opsel;
   assign bus.disp_opa      = use_rs1 ? bus.rf_rs1_data :
                              use_pc  ? cur_pc : '0;
   assign bus.disp_opb      = use_rs2 ? bus.rf_rs2_data :
                              use_imm ? imm : '0;
   assign bus.disp_rs1_data = bus.rf_rs1_data;
   assign bus.disp_rs2_data = bus.rf_rs2_data;
   assign bus.disp_imm      = imm;
   assign bus.disp_rs1_idx  = rs1;
   assign bus.disp_rd       = rd;
   assign bus.disp_rd_wen   = rd_wen;
   assign bus.disp_taken    = taken;
   assign bus.disp_cur_pc   = cur_pc;
   assign bus.disp_nxt_pc   = nxt_pc;

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - directed self-checking bench for issue_unit
module tb_issue_unit;

   logic        clk;
   logic        rst;
   logic [31:0] stall_cnt;
   logic [31:0] rf [32];

   int n_checks = 0;
   int n_fail   = 0;

   issue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ISSUE_Q_WIDTH(123)) bus ();

   issue_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ISSUE_Q_WIDTH(123), .REG_NUM(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   assign bus.rf_rs1_data = rf[bus.rf_rs1_addr];
   assign bus.rf_rs2_data = rf[bus.rf_rs2_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [122:0] mk(input logic [1:0] func, input logic [3:0] op,
                                       input logic [3:0] opsel, input logic [31:0] imm,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic rd_wen,
                                       input logic taken, input logic [31:0] nxt_pc,
                                       input logic [31:0] cur_pc);
      return {func, op, opsel, imm, rs1, rs2, rd, rd_wen, taken, nxt_pc, cur_pc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wb(input logic [4:0] r);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = r;
      step();
      bus.wb_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      n_checks++;
      if ({bus.alu_valid, bus.lsu_valid, bus.bpu_valid, bus.csr_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_valids: got %b want 0000",
                  {bus.alu_valid, bus.lsu_valid, bus.bpu_valid, bus.csr_valid});
      end
      n_checks++;
      if (stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
      step();
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.issue_q_ren !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ren: got %b want 1", bus.issue_q_ren);
      end
      n_checks++;
      if (bus.rf_rs1_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_rf_addr: got %0d want 0", bus.rf_rs1_addr);
      end
   endtask

   // ADD x3 = x1 + x2 dispatched the cycle after the pop
   task automatic test_add();
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b1100, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h4, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if ({bus.alu_valid, bus.lsu_valid, bus.bpu_valid, bus.csr_valid} !== 4'b1000) begin
         n_fail++;
         $display("FAIL add_valid: got %b want 1000",
                  {bus.alu_valid, bus.lsu_valid, bus.bpu_valid, bus.csr_valid});
      end
      n_checks++;
      if (bus.disp_opa !== 32'd5 || bus.disp_opb !== 32'd7) begin
         n_fail++;
         $display("FAIL add_operands: got opa=%0d opb=%0d want 5 7", bus.disp_opa, bus.disp_opb);
      end
      n_checks++;
      if (bus.disp_rd !== 5'd3 || bus.disp_rd_wen !== 1'b1) begin
         n_fail++;
         $display("FAIL add_rd: got rd=%0d wen=%b want 3 1", bus.disp_rd, bus.disp_rd_wen);
      end
      step();
   endtask

   // ADDI x4 = x3 + 1 waits for the x3 writeback (busy[3] set by test_add)
   task automatic test_raw();
      logic [31:0] base;
      base = stall_cnt;
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b1010, 32'd1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 32'h8, 32'h4);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.alu_valid !== 1'b0 || bus.issue_q_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_stall_%0d: got valid=%b ren=%b want 0 0", i, bus.alu_valid, bus.issue_q_ren);
         end
         step();
      end
      rf[3] = 32'd12;
      do_wb(5'd3);
      n_checks++;
      if (bus.alu_valid !== 1'b1 || bus.disp_opa !== 32'd12 || bus.disp_opb !== 32'd1) begin
         n_fail++;
         $display("FAIL raw_dispatch: got valid=%b opa=%0d opb=%0d want 1 12 1",
                  bus.alu_valid, bus.disp_opa, bus.disp_opb);
      end
      n_checks++;
      if (stall_cnt !== base + 32'd4) begin
         n_fail++;
         $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, base + 32'd4);
      end
      step();
      do_wb(5'd4);
   endtask

   task automatic test_back_to_back();
      logic [122:0] e [4];
      logic [3:0]   onehot [4];
      logic [4:0]   rds [4];
      e[0] = mk(2'd0, 4'd1, 4'b1100, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'h14, 32'h10);
      e[1] = mk(2'd1, 4'd2, 4'b1010, 32'd8, 5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 32'h18, 32'h14);
      e[2] = mk(2'd0, 4'd3, 4'b1100, 32'd0, 5'd2, 5'd1, 5'd12, 1'b1, 1'b0, 32'h1c, 32'h18);
      e[3] = mk(2'd3, 4'd4, 4'b1000, 32'd0, 5'd2, 5'd0, 5'd13, 1'b1, 1'b0, 32'h20, 32'h1c);
      onehot[0] = 4'b1000; onehot[1] = 4'b0100; onehot[2] = 4'b1000; onehot[3] = 4'b0001;
      rds[0] = 5'd10; rds[1] = 5'd11; rds[2] = 5'd12; rds[3] = 5'd13;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            bus.issue_q_rok   = 1'b1;
            bus.issue_q_rdata = e[i];
         end else begin
            bus.issue_q_rok = 1'b0;
         end
         #1;
         n_checks++;
         if (bus.issue_q_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ren_%0d: got %b want 1", i, bus.issue_q_ren);
         end
         if (i > 0) begin
            n_checks++;
            if ({bus.alu_valid, bus.lsu_valid, bus.bpu_valid, bus.csr_valid} !== onehot[i-1] ||
                bus.disp_rd !== rds[i-1]) begin
               n_fail++;
               $display("FAIL b2b_dispatch_%0d: got valids=%b rd=%0d want %b %0d", i,
                        {bus.alu_valid, bus.lsu_valid, bus.bpu_valid, bus.csr_valid},
                        bus.disp_rd, onehot[i-1], rds[i-1]);
            end
         end
         step();
      end
      do_wb(5'd10);
      do_wb(5'd11);
      do_wb(5'd12);
      do_wb(5'd13);
   endtask

   task automatic test_backpressure();
      logic [31:0] base;
      bus.bpu_ready     = 1'b0;
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd2, 4'd5, 4'b1111, 32'h10, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 32'h110, 32'h100);
      #1;
      step();
      base = stall_cnt;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b0010, 32'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h114, 32'h110);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.bpu_valid !== 1'b1 || bus.issue_q_ren !== 1'b0 ||
             bus.disp_opa !== 32'd5 || bus.disp_opb !== 32'd7 || bus.disp_imm !== 32'h10 ||
             bus.disp_cur_pc !== 32'h100 || bus.disp_nxt_pc !== 32'h110 || bus.disp_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL bpu_hold_%0d: got valid=%b ren=%b opa=%h opb=%h imm=%h pc=%h want 1 0 5 7 10 100",
                     i, bus.bpu_valid, bus.issue_q_ren, bus.disp_opa, bus.disp_opb,
                     bus.disp_imm, bus.disp_cur_pc);
         end
         step();
      end
      n_checks++;
      if (stall_cnt !== base + 32'd3) begin
         n_fail++;
         $display("FAIL bpu_stall_cnt: got %0d want %0d", stall_cnt, base + 32'd3);
      end
      bus.bpu_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.bpu_valid !== 1'b1 || bus.issue_q_ren !== 1'b1) begin
         n_fail++;
         $display("FAIL bpu_fire: got valid=%b ren=%b want 1 1", bus.bpu_valid, bus.issue_q_ren);
      end
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if ({bus.alu_valid, bus.bpu_valid} !== 2'b10 || bus.disp_opb !== 32'd3) begin
         n_fail++;
         $display("FAIL bpu_next: got alu=%b bpu=%b opb=%0d want 1 0 3",
                  bus.alu_valid, bus.bpu_valid, bus.disp_opb);
      end
      step();
   endtask

   task automatic test_flush();
      logic [31:0] s0;
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b0010, 32'd9, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rdata = mk(2'd1, 4'd6, 4'b1010, 32'd4, 5'd20, 5'd0, 5'd21, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if (bus.lsu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_lw_hazard: got %b want 0", bus.lsu_valid);
      end
      s0 = stall_cnt;
      bus.flush = 1'b1;
      #1;
      n_checks++;
      if (bus.lsu_valid !== 1'b0 || bus.issue_q_ren !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cycle: got valid=%b ren=%b want 0 0", bus.lsu_valid, bus.issue_q_ren);
      end
      step();
      bus.flush = 1'b0;
      #1;
      n_checks++;
      if (bus.issue_q_ren !== 1'b1 || bus.lsu_valid !== 1'b0 || bus.rf_rs1_addr !== 5'd0 ||
          stall_cnt !== s0) begin
         n_fail++;
         $display("FAIL flush_empty: got ren=%b valid=%b rs1_addr=%0d stall=%0d want 1 0 0 %0d",
                  bus.issue_q_ren, bus.lsu_valid, bus.rf_rs1_addr, stall_cnt, s0);
      end
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b1000, 32'd0, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_busy_kept: got %b want 0", bus.alu_valid);
      end
      do_wb(5'd20);
      n_checks++;
      if (bus.alu_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_after_wb: got %b want 1", bus.alu_valid);
      end
      step();
   endtask

   task automatic test_set_wins();
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b0010, 32'd1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      bus.wb_valid    = 1'b1;
      bus.wb_rd       = 5'd5;
      #1;
      n_checks++;
      if (bus.alu_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL setwins_fire: got %b want 1", bus.alu_valid);
      end
      step();
      bus.wb_valid      = 1'b0;
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b1000, 32'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL setwins_busy5: got valid=%b want 0", bus.alu_valid);
      end
      do_wb(5'd5);
      n_checks++;
      if (bus.alu_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL setwins_cleared: got %b want 1", bus.alu_valid);
      end
      step();
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b0010, 32'd2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rdata = mk(2'd0, 4'd1, 4'b0010, 32'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_valid !== 1'b1 || bus.disp_op !== 4'd1) begin
         n_fail++;
         $display("FAIL rd0_no_busy: got valid=%b op=%0d want 1 1", bus.alu_valid, bus.disp_op);
      end
      step();
   endtask

   task automatic test_async_reset();
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b0010, 32'd1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b1000, 32'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.alu_valid !== 1'b0 || stall_cnt !== 32'd0 || bus.issue_q_ren !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b stall=%0d ren=%b want 0 0 1",
                  bus.alu_valid, stall_cnt, bus.issue_q_ren);
      end
      step();
      rst = 1'b0;
      bus.issue_q_rok   = 1'b1;
      bus.issue_q_rdata = mk(2'd0, 4'd0, 4'b1000, 32'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      step();
      bus.issue_q_rok = 1'b0;
      #1;
      n_checks++;
      if (bus.alu_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset_busy_cleared: got %b want 1", bus.alu_valid);
      end
      step();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd100 + i;
      rf[0] = 32'd0;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rst               = 1'b1;
      bus.issue_q_rok   = 1'b0;
      bus.issue_q_rdata = '0;
      bus.alu_ready     = 1'b1;
      bus.lsu_ready     = 1'b1;
      bus.bpu_ready     = 1'b1;
      bus.csr_ready     = 1'b1;
      bus.wb_valid      = 1'b0;
      bus.wb_rd         = 5'd0;
      bus.flush         = 1'b0;

      test_reset();
      test_add();
      test_raw();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_set_wins();
      test_async_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/issue_unit.md
# issue_unit

Issue stage between the decoded-instruction issue queue and the four function units (ALU, LSU, BPU, CSR). It pops one 123-bit decoded entry per cycle into a single holding register, checks a 32-entry register scoreboard for RAW/WAW hazards, reads the register file, and dispatches the operation in order to the selected unit with a per-unit valid/ready handshake. Writeback events clear scoreboard bits, and a flush input squashes the held entry after a branch redirect.

## Interface
- DATA_WIDTH, 32, register/immediate width
- ADDR_WIDTH, 32, PC width
- ISSUE_Q_WIDTH, 123, issue-queue entry width
- REG_NUM, 32, architectural registers (x0 hard-wired zero)
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- issue_q_rok  in  1  queue has an entry
- issue_q_ren  out  1  pop request
- issue_q_rdata  in  123  entry, MSB→LSB: func[122:121], op[120:117], opsel[116:113]={use_rs1,use_rs2,use_imm,use_pc}, imm[112:81], rs1[80:76], rs2[75:71], rd[70:66], rd_wen[65], taken[64], nxt_pc[63:32], cur_pc[31:0]
- rf_rs1_addr, rf_rs2_addr  out  5  register-file read addresses (combinational read)
- rf_rs1_data, rf_rs2_data  in  32  read data
- alu_valid, lsu_valid, bpu_valid, csr_valid  out  1  one-hot dispatch valid
- alu_ready, lsu_ready, bpu_ready, csr_ready  in  1  unit accepts
- disp_op  out  4  operator code
- disp_opsel  out  4  operand-select bits, passed through
- disp_opa  out  32  use_rs1 ? rs1_data : use_pc ? cur_pc : 0
- disp_opb  out  32  use_rs2 ? rs2_data : use_imm ? imm : 0
- disp_rs1_data, disp_rs2_data, disp_imm  out  32  raw operands (stores/branches/CSR)
- disp_rs1_idx  out  5  rs1 field (CSR zimm)
- disp_rd, disp_rd_wen  out  5/1  destination
- disp_taken, disp_cur_pc, disp_nxt_pc  out  1/32/32  prediction info
- wb_valid  in  1  writeback event
- wb_rd  in  5  written register
- flush  in  1  squash held entry
- stall_cnt  out  32  saturating hazard-stall counter

## Operation
- States: EMPTY (no held entry), HELD (entry valid). Reset → EMPTY.
- issue_q_ren = !flush & (EMPTY | fire). issue_q_ren & issue_q_rok loads entry → HELD; with fire and no load → EMPTY.
- Hazard (HELD only): (use_rs1 & rs1≠0 & busy[rs1]) | (use_rs2 & rs2≠0 & busy[rs2]) | (rd_wen & rd≠0 & busy[rd]). busy[] is the registered scoreboard; no same-cycle writeback bypass.
- Dispatch valid = HELD & !hazard & !flush; exactly the unit selected by func (0 ALU, 1 LSU, 2 BPU, 3 CSR) is asserted. fire = valid & that unit's ready.
- Scoreboard: on fire with rd_wen & rd≠0, set busy[rd]; on wb_valid & wb_rd≠0, clear busy[wb_rd]. Same-cycle set and clear on the same register: set wins. busy[0] is always 0.
- flush: next state EMPTY; no fire, no pop in that cycle. Scoreboard is untouched, because every dispatched op writes back.
- stall_cnt increments each cycle HELD & (hazard | selected ready low) & !flush, and saturates at 0xFFFFFFFF.
- rf addresses are always driven from held rs1/rs2, and from 0 when EMPTY.

## Timing
- Reset (async): EMPTY, busy=0, stall_cnt=0, all *_valid=0. issue_q_ren=1 once rst deasserts (combinational from EMPTY).
- Latency: entry popped at edge N is dispatchable in cycle N+1. Back-to-back independent entries issue at one per cycle.
- Dependent op after writeback: wb at edge M clears busy, and the dependent op dispatches in cycle M+1 at earliest.
- Valid holds with stable payload until fire; a unit may hold ready low indefinitely.
- Dispatch outputs are combinational from the holding register and rf data. rf must be write-through or the writeback must precede the clear.
- rst mid-operation: held entry is dropped and busy is cleared immediately.

## Test plan
- Reset, then push ADD (func0, opsel 1100, rs1=1, rs2=2, rd=3) with x1=5, x2=7 -> alu_valid in cycle after pop, disp_opa=5, disp_opb=7, busy[3] set on fire.
- ADD rd=3, then ADDI rs1=3, alu_ready=1 -> second op stalls until wb_valid/wb_rd=3, then dispatches the next cycle, and stall_cnt equals the stalled cycles.
- Stream of 4 independent ops with all readys high -> one dispatch per cycle and issue_q_ren continuously 1.
- BEQ (func2, opsel 1111, imm=0x10, cur_pc=0x100) with bpu_ready=0 for 3 cycles -> bpu_valid held 3 cycles with stable payload, pop blocked, fire on cycle 4.
- Held LW with busy rs1, flush=1 -> lsu_valid never asserts, state EMPTY, and busy unchanged.
- wb_valid/wb_rd=5 in the same cycle as firing an op with rd=5 -> busy[5]=1 afterward. Writing rd=0 never sets busy.
